// File: rtl/chunked_adder_if.sv
// Handshake bundle for chunked_adder: operand/mode request and result response.
interface chunked_adder_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] num1;
    logic [WIDTH-1:0] num2;
    logic             sub;
    logic [WIDTH-1:0] out;
    logic             cout;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output in_valid, num1, num2, sub, out_ready,
        input  in_ready, out, cout, out_valid
    );

    modport slave (
        input  in_valid, num1, num2, sub, out_ready,
        output in_ready, out, cout, out_valid
    );
endinterface

// File: rtl/chunked_adder.sv
// Multi-cycle adder/subtractor: one CHUNK-bit slice per clock, LSB slice first,
// carry kept in a register between slices. WIDTH must match the bus WIDTH.
module chunked_adder #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    chunked_adder_if.slave bus
);
    localparam int STEPS = WIDTH / CHUNK;
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] out_q;
    logic             carry_q;
    logic             cout_q;
    logic [CW-1:0]    cnt_q;
    logic [CHUNK-1:0] a_slice;
    logic [CHUNK-1:0] b_slice;
    logic [CHUNK:0]   sum;
    logic             last;

    // Slice mux compares the counter against constants so every select is static.
    always_comb begin
        a_slice = '0;
        b_slice = '0;
        for (int k = 0; k < STEPS; k++) begin
            if (cnt_q == CW'(k)) begin
                a_slice = a_q[k*CHUNK +: CHUNK];
                b_slice = b_q[k*CHUNK +: CHUNK];
            end
        end
        sum = {1'b0, a_slice} + {1'b0, b_slice} + {{CHUNK{1'b0}}, carry_q};
    end

    assign last = (cnt_q == LAST);

    // NOTE: state_d gets its default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.in_valid)  state_d = BUSY;
            BUSY:    if (last)          state_d = DONE;
            DONE:    if (bus.out_ready) state_d = IDLE;
            default:                    state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Subtraction is num1 + ~num2 + 1: invert B at capture and seed the carry with sub.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            out_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_q     <= bus.num1;
                        b_q     <= bus.sub ? ~bus.num2 : bus.num2;
                        carry_q <= bus.sub;
                        cnt_q   <= '0;
                    end
                end
                BUSY: begin
                    for (int k = 0; k < STEPS; k++) begin
                        if (cnt_q == CW'(k)) out_q[k*CHUNK +: CHUNK] <= sum[CHUNK-1:0];
                    end
                    carry_q <= sum[CHUNK];
                    cnt_q   <= last ? '0 : cnt_q + CW'(1);
                    if (last) cout_q <= sum[CHUNK];
                end
                default: ;
            endcase
        end
    end

    // Handshake flags decode registered state only.
    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.out       = out_q;
    assign bus.cout      = cout_q;
endmodule

// File: tb/tb_chunked_adder.sv
// Directed bench for chunked_adder in three configurations: 8/2, 4/1 and 16/16.
module tb_chunked_adder;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  in_valid;
    logic [15:0] num1;
    logic [15:0] num2;
    logic        sub;
    logic        out_ready;

    always #5 clk = ~clk;

    chunked_adder_if #(.WIDTH(8))  if8();
    chunked_adder_if #(.WIDTH(4))  if4();
    chunked_adder_if #(.WIDTH(16)) if16();

    assign if8.in_valid   = in_valid[0];
    assign if8.num1       = num1[7:0];
    assign if8.num2       = num2[7:0];
    assign if8.sub        = sub;
    assign if8.out_ready  = out_ready;
    assign if4.in_valid   = in_valid[1];
    assign if4.num1       = num1[3:0];
    assign if4.num2       = num2[3:0];
    assign if4.sub        = sub;
    assign if4.out_ready  = out_ready;
    assign if16.in_valid  = in_valid[2];
    assign if16.num1      = num1;
    assign if16.num2      = num2;
    assign if16.sub       = sub;
    assign if16.out_ready = out_ready;

    chunked_adder #(.WIDTH(8),  .CHUNK(2))  u_add8  (.clk(clk), .rst_n(rst_n), .bus(if8.slave));
    chunked_adder #(.WIDTH(4),  .CHUNK(1))  u_add4  (.clk(clk), .rst_n(rst_n), .bus(if4.slave));
    chunked_adder #(.WIDTH(16), .CHUNK(16)) u_add16 (.clk(clk), .rst_n(rst_n), .bus(if16.slave));

    int          sel;
    logic        sel_ready;
    logic        sel_valid;
    logic        sel_cout;
    logic [15:0] sel_out;

    always_comb begin
        sel_ready = 1'b0;
        sel_valid = 1'b0;
        sel_cout  = 1'b0;
        sel_out   = '0;
        case (sel)
            0: begin sel_ready = if8.in_ready;  sel_valid = if8.out_valid;  sel_cout = if8.cout;  sel_out = {8'h00, if8.out};  end
            1: begin sel_ready = if4.in_ready;  sel_valid = if4.out_valid;  sel_cout = if4.cout;  sel_out = {12'h000, if4.out}; end
            2: begin sel_ready = if16.in_ready; sel_valid = if16.out_valid; sel_cout = if16.cout; sel_out = if16.out;          end
            default: ;
        endcase
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One transaction on DUT s; inputs are scrambled right after acceptance, and
    // out_ready is held low for `hold` cycles once the result is presented.
    task automatic run_op(input int s, input int steps, input logic [15:0] a, input logic [15:0] b,
                          input logic sb, input logic [15:0] exp_out, input logic exp_cout,
                          input int hold, input string tag);
        int          cyc;
        logic [15:0] held_out;
        logic        held_cout;
        @(negedge clk);
        sel         = s;
        num1        = a;
        num2        = b;
        sub         = sb;
        out_ready   = (hold == 0);
        in_valid[s] = 1'b1;
        #1 check({tag, "/idle_ready"}, 32'(sel_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = '0;
        num1     = ~a;
        num2     = ~b;
        sub      = ~sb;
        check({tag, "/busy_ready"}, 32'(sel_ready), 32'd0);
        check({tag, "/busy_valid"}, 32'(sel_valid), 32'd0);
        cyc = 0;
        while (!sel_valid && cyc < 40) begin
            @(posedge clk);
            #1 cyc++;
        end
        check({tag, "/latency"}, 32'(cyc), 32'(steps));
        check({tag, "/out"}, 32'(sel_out), 32'(exp_out));
        check({tag, "/cout"}, 32'(sel_cout), 32'(exp_cout));
        held_out  = sel_out;
        held_cout = sel_cout;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            check({tag, "/hold_out"}, 32'(sel_out), 32'(held_out));
            check({tag, "/hold_cout"}, 32'(sel_cout), 32'(held_cout));
            check({tag, "/hold_valid"}, 32'(sel_valid), 32'd1);
            check({tag, "/hold_ready"}, 32'(sel_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check({tag, "/done_valid"}, 32'(sel_valid), 32'd0);
        check({tag, "/done_ready"}, 32'(sel_ready), 32'd1);
    endtask

    initial begin
        logic [4:0] exh;
        rst_n     = 1'b0;
        in_valid  = '0;
        num1      = '0;
        num2      = '0;
        sub       = 1'b0;
        out_ready = 1'b1;
        sel       = 0;

        #2;
        check("rst/ready8", 32'(if8.in_ready), 32'd1);
        check("rst/ready4", 32'(if4.in_ready), 32'd1);
        check("rst/ready16", 32'(if16.in_ready), 32'd1);
        check("rst/valid8", 32'(if8.out_valid), 32'd0);
        check("rst/out8", 32'(if8.out), 32'd0);
        check("rst/cout8", 32'(if8.cout), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1 check("rst/ready_after", 32'(if8.in_ready), 32'd1);

        run_op(0, 4, 16'd200, 16'd100, 1'b0, 16'h002C, 1'b1, 10, "add8_bp");
        run_op(0, 4, 16'd5,   16'd7,   1'b1, 16'h00FE, 1'b0, 0,  "sub8_borrow");
        run_op(0, 4, 16'd7,   16'd5,   1'b1, 16'h0002, 1'b1, 0,  "sub8");

        // Abort 0x12+0x34 two cycles into BUSY; out holds a partial 0x06 by then.
        @(negedge clk);
        sel         = 0;
        num1        = 16'h0012;
        num2        = 16'h0034;
        sub         = 1'b0;
        in_valid[0] = 1'b1;
        @(posedge clk);
        #1 in_valid = '0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst/out", 32'(if8.out), 32'd0);
        check("midrst/cout", 32'(if8.cout), 32'd0);
        check("midrst/valid", 32'(if8.out_valid), 32'd0);
        check("midrst/ready", 32'(if8.in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(0, 4, 16'h00FF, 16'h0001, 1'b0, 16'h0000, 1'b1, 0, "add8_after_rst");
        run_op(0, 4, 16'h0080, 16'h0080, 1'b1, 16'h0000, 1'b1, 0, "sub8_equal");
        run_op(2, 1, 16'hFFFF, 16'hFFFF, 1'b0, 16'hFFFE, 1'b1, 0, "add16");
        run_op(2, 1, 16'h0000, 16'h0001, 1'b1, 16'hFFFF, 1'b0, 3, "sub16_bp");

        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                exh = 5'(i) + 5'(j);
                run_op(1, 4, 16'(i), 16'(j), 1'b0, {12'h000, exh[3:0]}, exh[4], 0,
                       $sformatf("exh4 %0d+%0d", i, j));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
